reg_transfer_ctrl: RTL and testbench

- Initiator side of the register load interface. Each register in the datapath exposes an 8-bit data input, an 8-bit data output and a one-cycle load select.
- The block accepts one transfer command at a time over a valid/ready handshake. It reads a source register's output or an immediate, optionally increments or decrements the value, then drives the shared write bus. It pulses exactly one destination load select for one cycle.
- It sits between the CPU control unit and the general-purpose register bank.

---
 rtl/reg_transfer_ctrl.sv | 131 +++++++++++++
 tb/tb_reg_transfer_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_transfer_ctrl.sv
// Register-transfer initiator: accepts MOV/LDI/INC/DEC commands, drives the shared
// write bus and strobes one destination load select.
module reg_transfer_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [SEL_W-1:0]      cmd_src,
    input  logic [SEL_W-1:0]      cmd_dst,
    input  logic [7:0]            cmd_imm,
    input  logic [NUM_REGS*8-1:0] reg_data,
    output logic [7:0]            bus_data,
    output logic [NUM_REGS-1:0]   reg_sel,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    localparam logic [1:0]     OP_MOV = 2'b00;
    localparam logic [1:0]     OP_LDI = 2'b01;
    localparam logic [1:0]     OP_INC = 2'b10;
    localparam logic [1:0]     OP_DEC = 2'b11;
    localparam logic [SEL_W:0] NREGS  = (SEL_W+1)'(NUM_REGS);

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [SEL_W-1:0]      src_q, dst_q;
    logic [7:0]            imm_q;
    logic [7:0]            tmp_q, tmp_d;
    logic                  errFlag_q, errFlag_d;
    logic [NUM_REGS-1:0]   selOut_q, selOut_d;
    logic                  doneOut_q, doneOut_d;
    logic                  errOut_q, errOut_d;
    logic                  ready_q, ready_d;
    logic [7:0]            srcVal;
    logic [NUM_REGS-1:0]   dstOneHot;
    logic                  illegal;
    logic                  accept;

    always_comb begin
        srcVal    = 8'h00;
        dstOneHot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i)) srcVal = reg_data[i*8 +: 8];
            if (dst_q == SEL_W'(i)) dstOneHot[i] = 1'b1;
        end
    end

    assign illegal = ({1'b0, dst_q} >= NREGS) ||
                     ((op_q != OP_LDI) && ({1'b0, src_q} >= NREGS));
    assign accept  = cmd_valid && ready_q && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        tmp_d     = tmp_q;
        errFlag_d = errFlag_q;
        unique case (state_q)
            IDLE: if (accept) state_d = FETCH;
            FETCH: begin
                if (illegal) begin
                    errFlag_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    unique case (op_q)
                        OP_MOV: tmp_d = srcVal;
                        OP_LDI: tmp_d = imm_q;
                        OP_INC: tmp_d = srcVal + 8'h01;
                        OP_DEC: tmp_d = srcVal - 8'h01;
                    endcase
                    state_d = WRITE;
                end
            end
            WRITE: state_d = DONE;
            DONE: begin
                errFlag_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Outputs are registered one cycle behind the state they decode, so the
    // strobe/done/ready timing trails the FSM by exactly one clock.
    always_comb begin
        selOut_d  = (state_q == WRITE) ? dstOneHot : '0;
        doneOut_d = (state_q == DONE);
        errOut_d  = (state_q == DONE) && errFlag_q;
        ready_d   = (state_q == IDLE) && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MOV;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= 8'h00;
            tmp_q     <= 8'h00;
            errFlag_q <= 1'b0;
            selOut_q  <= '0;
            doneOut_q <= 1'b0;
            errOut_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmp_q     <= tmp_d;
            errFlag_q <= errFlag_d;
            selOut_q  <= selOut_d;
            doneOut_q <= doneOut_d;
            errOut_q  <= errOut_d;
            ready_q   <= ready_d;
            if (accept) begin
                op_q  <= cmd_op;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                imm_q <= cmd_imm;
            end
        end
    end

    assign cmd_ready = ready_q;
    assign bus_data  = tmp_q;
    assign reg_sel   = selOut_q;
    assign done      = doneOut_q;
    assign err       = errOut_q;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Directed bench for reg_transfer_ctrl: a 4-register instance drives a model bank,
// a 3-register instance covers the out-of-range source error path.
module tb_reg_transfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid4 = 1'b0, valid3 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [1:0]  src = 2'b00, dst = 2'b00;
    logic [7:0]  imm = 8'h00;
    logic        ready4, ready3, done4, done3, err4, err3;
    logic [7:0]  bus4, bus3;
    logic [3:0]  sel4;
    logic [2:0]  sel3;
    logic [7:0]  bank [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [31:0] data4;
    logic [23:0] data3;
    int          checks = 0;
    int          errors = 0;

    localparam logic [1:0] MOV = 2'b00, LDI = 2'b01, INC = 2'b10, DEC = 2'b11;

    always #5 clk = ~clk;

    assign data4 = {bank[3], bank[2], bank[1], bank[0]};
    assign data3 = {bank[2], bank[1], bank[0]};

    reg_transfer_ctrl #(.NUM_REGS(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(valid4), .cmd_ready(ready4),
        .cmd_op(op), .cmd_src(src), .cmd_dst(dst), .cmd_imm(imm),
        .reg_data(data4), .bus_data(bus4), .reg_sel(sel4), .done(done4), .err(err4)
    );

    reg_transfer_ctrl #(.NUM_REGS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(valid3), .cmd_ready(ready3),
        .cmd_op(op), .cmd_src(src), .cmd_dst(dst), .cmd_imm(imm),
        .reg_data(data3), .bus_data(bus3), .reg_sel(sel3), .done(done3), .err(err3)
    );

    // Model register bank loaded by the 4-register instance
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (sel4[i]) bank[i] <= bus4;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command on dut4 at a falling edge; returns just after acceptance
    task automatic applyStimulus(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                                 input logic [7:0] im);
        checkOutput("readyBeforeCmd", {31'd0, ready4}, 32'd1);
        op = o; src = s; dst = d; imm = im;
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
    endtask

    task automatic runCmd(input string tag, input logic [1:0] o, input logic [1:0] s,
                          input logic [1:0] d, input logic [7:0] im,
                          input logic [3:0] expSel, input logic [7:0] expBus);
        applyStimulus(o, s, d, im);
        checkOutput({tag, "_readyLow"}, {31'd0, ready4}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_selEarly"}, {28'd0, sel4}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_sel"}, {28'd0, sel4}, {28'd0, expSel});
        checkOutput({tag, "_bus"}, {24'd0, bus4}, {24'd0, expBus});
        checkOutput({tag, "_doneEarly"}, {31'd0, done4}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_selOff"}, {28'd0, sel4}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done4}, 32'd1);
        checkOutput({tag, "_err"}, {31'd0, err4}, 32'd0);
        checkOutput({tag, "_readyStillLow"}, {31'd0, ready4}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_readyBack"}, {31'd0, ready4}, 32'd1);
        checkOutput({tag, "_doneOff"}, {31'd0, done4}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, ready4}, 32'd1);
        checkOutput("rst_bus", {24'd0, bus4}, 32'h00);
        checkOutput("rst_sel", {28'd0, sel4}, 32'd0);
        checkOutput("rst_done", {31'd0, done4}, 32'd0);
        checkOutput("rst_err", {31'd0, err4}, 32'd0);

        runCmd("ldiR2", LDI, 2'd0, 2'd2, 8'hA5, 4'b0100, 8'hA5);
        checkOutput("bankR2", {24'd0, bank[2]}, 32'hA5);
        runCmd("ldiR1", LDI, 2'd0, 2'd1, 8'h3C, 4'b0010, 8'h3C);
        runCmd("movR1R3", MOV, 2'd1, 2'd3, 8'h00, 4'b1000, 8'h3C);
        checkOutput("bankR3", {24'd0, bank[3]}, 32'h3C);
        runCmd("ldiR0", LDI, 2'd0, 2'd0, 8'hFF, 4'b0001, 8'hFF);
        runCmd("incWrap", INC, 2'd0, 2'd0, 8'h00, 4'b0001, 8'h00);
        checkOutput("bankR0inc", {24'd0, bank[0]}, 32'h00);
        runCmd("decWrap", DEC, 2'd0, 2'd0, 8'h00, 4'b0001, 8'hFF);
        checkOutput("bankR0dec", {24'd0, bank[0]}, 32'hFF);

        // Out-of-range source on the 3-register instance
        checkOutput("e_readyBefore", {31'd0, ready3}, 32'd1);
        op = MOV; src = 2'd3; dst = 2'd0; imm = 8'h00;
        valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        checkOutput("e_doneEarly", {31'd0, done3}, 32'd0);
        @(negedge clk);
        checkOutput("e_sel1", {29'd0, sel3}, 32'd0);
        @(negedge clk);
        checkOutput("e_done", {31'd0, done3}, 32'd1);
        checkOutput("e_err", {31'd0, err3}, 32'd1);
        checkOutput("e_sel2", {29'd0, sel3}, 32'd0);
        @(negedge clk);
        checkOutput("e_readyBack", {31'd0, ready3}, 32'd1);
        checkOutput("e_errOff", {31'd0, err3}, 32'd0);

        // Busy period: fields change while valid stays high
        @(negedge clk);
        op = LDI; src = 2'd0; dst = 2'd2; imm = 8'h11;
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b_ready1", {31'd0, ready4}, 32'd0);
        dst = 2'd3; imm = 8'h22;
        @(negedge clk);
        checkOutput("b_ready2", {31'd0, ready4}, 32'd0);
        imm = 8'h33;
        @(negedge clk);
        checkOutput("b_ready3", {31'd0, ready4}, 32'd0);
        checkOutput("b_sel", {28'd0, sel4}, 32'b0100);
        checkOutput("b_bus", {24'd0, bus4}, 32'h11);
        valid4 = 1'b0;
        @(negedge clk);
        checkOutput("b_done", {31'd0, done4}, 32'd1);
        @(negedge clk);
        checkOutput("b_readyBack", {31'd0, ready4}, 32'd1);
        checkOutput("b_bankR2", {24'd0, bank[2]}, 32'h11);
        checkOutput("b_bankR3", {24'd0, bank[3]}, 32'h3C);

        // Reset while the FSM is in WRITE aborts the transfer
        applyStimulus(LDI, 2'd0, 2'd1, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("a_sel", {28'd0, sel4}, 32'd0);
        checkOutput("a_done", {31'd0, done4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("a_sel2", {28'd0, sel4}, 32'd0);
        checkOutput("a_done2", {31'd0, done4}, 32'd0);
        checkOutput("a_ready", {31'd0, ready4}, 32'd1);
        checkOutput("a_bankR1", {24'd0, bank[1]}, 32'h3C);
        runCmd("afterAbort", LDI, 2'd0, 2'd1, 8'h5A, 4'b0010, 8'h5A);
        checkOutput("a_bankR1new", {24'd0, bank[1]}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
